mcycle_issuer: RTL and testbench
================================

# mcycle_issuer

Processor-side initiator for the multi-cycle multiply/divide unit (`MCycle`). It accepts one MUL/DIV request from the decode/execute stage and latches the operands. It drives the `Start`/`MCycleOp`/`Operand1`/`Operand2` handshake into `MCycle`, waits out `Busy`, and captures the selected result half. It holds the pipeline stall for the whole operation and returns a registered result with a one-cycle `Done` pulse.

## Interface
- `WIDTH`, default 32: operand/result width; must match the attached `MCycle`.
- `TIMEOUT_CYCLES`, default 2*WIDTH+8: watchdog limit; used only with `MCYCLE_ISSUER_TIMEOUT_EN`.

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `Req`  in  1  request from execute stage; level, held until `Done`.
- `ReqOp`  in  2  00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
- `ReqSel`  in  1  0 selects `Result1` (mul low / quotient); 1 selects `Result2` (mul high / remainder).
- `ReqA`, `ReqB`  in  WIDTH  operands: multiplicand/multiplier or dividend/divisor.
- `Stall`  out  1  freeze upstream pipeline.
- `Done`  out  1  one-cycle pulse; `Result` is valid in this cycle.
- `Result`  out  WIDTH  captured selected result; holds until the next capture.
- `Err`  out  1  timeout flag, valid with `Done`.
- `Start`  out  1  to `MCycle`.
- `MCycleOp`  out  2  to `MCycle`.
- `Operand1`, `Operand2`  out  WIDTH  to `MCycle`.
- `Result1`, `Result2`  in  WIDTH  from `MCycle`.
- `Busy`  in  1  from `MCycle`; may be combinational on `Start`.

## Operation
- State machine: IDLE, LAUNCH, WAIT, DONE; state is registered.
- IDLE:
  - On `Req`=1, latch `ReqOp`, `ReqSel`, `ReqA`, `ReqB`, then go to LAUNCH.
  - `Stall` = `Req` combinationally, so the request cycle is already stalled.
- LAUNCH: `Start`=1. If `Busy`=1 at the clock edge, go to WAIT; otherwise stay in LAUNCH.
- WAIT: `Start`=0. When `Busy`=0 at the edge, capture `Result1` or `Result2` per the latched `ReqSel` into `Result`, then go to DONE.
- DONE: `Done`=1, `Stall`=0; unconditionally go to IDLE.
  - If `Req` is still high in IDLE after DONE, it is treated as a new request.
- `Stall` = (IDLE & `Req`) | LAUNCH | WAIT.
- `MCycleOp`, `Operand1`, `Operand2` come only from the latched registers. They are stable from LAUNCH through DONE, so changes on `Req*` inputs mid-operation are ignored.
- `Start` is asserted only in LAUNCH. It is never held across operations, so `MCycle` cannot relaunch back-to-back without a new request.
- There is no arithmetic in the block. Result selection is a pure mux; signedness is conveyed only via `MCycleOp`.

## Timing
- Reset values: state IDLE; `Start`, `Done`, `Err` 0; `MCycleOp` 00; `Operand1`, `Operand2`, `Result` 0; `Stall` = `Req`.
- `RESET` mid-operation aborts immediately. `Start` drops asynchronously and no `Done` is produced. `MCycle` shares the same `RESET`.
- Latency, with request accepted at edge 0:
  - LAUNCH occupies cycle 1.
  - With `Busy` seen at edge 1 and `Busy` high for N cycles, `Result` is captured at edge N+1.
  - `Done` is high in cycle N+2; `Stall` falls in the same cycle.
- `Busy` already low when WAIT is entered (a zero-length op) captures at the first WAIT edge.
- `Done` is never asserted for two consecutive cycles.

## Configuration
- `MCYCLE_ISSUER_TIMEOUT_EN` defined:
  - A counter clears on entering LAUNCH and increments each cycle in LAUNCH/WAIT.
  - Reaching `TIMEOUT_CYCLES` forces DONE with `Err`=1 and `Result`=0, and drops `Start`.
- Not defined: no counter is built and `Err` is tied to 0; behaviour is otherwise identical.

## Test plan
- WIDTH=4, real `MCycle`: signed mul, A=1111, B=1111, Sel=0 -> `Result`=0001; repeat with Sel=1 -> `Result`=0000. `Stall` is high from the request cycle until `Done`.
- Unsigned mul, A=1110, B=1111 (210): Sel=0 -> 0010; Sel=1 -> 1101. `Done` is a single-cycle pulse.
- Signed div 7 / -3 (0111 / 1101): Sel=0 -> 1110 (-2); Sel=1 -> 0001. Unsigned div 13 / 7 -> quotient 0001, remainder 0110.
- Change `ReqA`/`ReqOp` while in WAIT -> `Operand1`/`MCycleOp` remain at the latched values and the result is unaffected. `Start` is high only during LAUNCH.
- Assert `RESET` mid-WAIT -> `Start`=0 and the block is in IDLE without `Done`. A request after reset release completes correctly.
- With macro defined, using a stub `MCycle` that holds `Busy`=1 forever: `Done` and `Err`=1 after `TIMEOUT_CYCLES`, with `Result`=0. Without the macro, `Stall` stays high indefinitely.

Source files
------------

// File: rtl/mcycle_issuer.sv
`default_nettype none
// ============================================================================
// Module      : mcycle_issuer
// Description : Processor-side initiator for the multi-cycle MUL/DIV unit.
//               Latches one request, runs the Start/Busy handshake, captures
//               the selected result half and stalls the pipeline meanwhile.
//               Optional watchdog: define MCYCLE_ISSUER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mcycle_issuer #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 2 * WIDTH + 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Req,
    input  logic [1:0]       ReqOp,
    input  logic             ReqSel,
    input  logic [WIDTH-1:0] ReqA,
    input  logic [WIDTH-1:0] ReqB,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Err,
    output logic             Start,
    output logic [1:0]       MCycleOp,
    output logic [WIDTH-1:0] Operand1,
    output logic [WIDTH-1:0] Operand2,
    input  logic [WIDTH-1:0] Result1,
    input  logic [WIDTH-1:0] Result2,
    input  logic             Busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic             sel_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mcycle_issuer: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MCYCLE_ISSUER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;
    logic             tmo_hit;
    logic             active;

    assign active  = (state == S_LAUNCH) || (state == S_WAIT);
    // Counter reads TIMEOUT_CYCLES-1 in the last allowed active cycle.
    assign tmo_hit = active && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            op_q     <= 2'b00;
            sel_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
`ifdef MCYCLE_ISSUER_TIMEOUT_EN
            tmo_cnt  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (Req) begin
                        op_q  <= ReqOp;
                        sel_q <= ReqSel;
                        a_q   <= ReqA;
                        b_q   <= ReqB;
                        state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (Busy) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!Busy) begin
                        result_q <= sel_q ? Result2 : Result1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

`ifdef MCYCLE_ISSUER_TIMEOUT_EN
            if (state == S_IDLE) begin
                tmo_cnt <= '0;
            end else if (active) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end

            if (state == S_DONE) begin
                err_q <= 1'b0;
            end

            // A genuine completion on the same edge wins over the watchdog.
            if (tmo_hit && !((state == S_WAIT) && !Busy)) begin
                state    <= S_DONE;
                result_q <= '0;
                err_q    <= 1'b1;
            end
`endif
        end
    end

    assign Start    = (state == S_LAUNCH);
    assign Done     = (state == S_DONE);
    assign Stall    = ((state == S_IDLE) && Req) || (state == S_LAUNCH) || (state == S_WAIT);
    assign MCycleOp = op_q;
    assign Operand1 = a_q;
    assign Operand2 = b_q;
    assign Result   = result_q;

`ifdef MCYCLE_ISSUER_TIMEOUT_EN
    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mcycle_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcycle_issuer
// Description : Scoreboard bench for mcycle_issuer with a behavioural MCycle
//               stand-in whose Busy length is programmable per operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcycle_issuer;

    localparam int W  = 4;
    localparam int TO = 2 * W + 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Req;
    logic [1:0]   ReqOp;
    logic         ReqSel;
    logic [W-1:0] ReqA;
    logic [W-1:0] ReqB;
    logic         Stall;
    logic         Done;
    logic [W-1:0] Result;
    logic         Err;
    logic         Start;
    logic [1:0]   MCycleOp;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;

    typedef struct packed {
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    int       stub_n = 1;
    logic     hang   = 1'b0;
    logic [7:0] bcnt;

    mcycle_issuer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RESET(RESET), .Req(Req), .ReqOp(ReqOp), .ReqSel(ReqSel),
        .ReqA(ReqA), .ReqB(ReqB), .Stall(Stall), .Done(Done), .Result(Result),
        .Err(Err), .Start(Start), .MCycleOp(MCycleOp), .Operand1(Operand1),
        .Operand2(Operand2), .Result1(Result1), .Result2(Result2), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    // MCycle stand-in: Busy is high during Start and for stub_n-1 further cycles.
    always @(posedge CLK or posedge RESET) begin
        if (RESET)                   bcnt <= 8'd0;
        else if (Start && bcnt == 0) bcnt <= 8'(stub_n - 1);
        else if (bcnt != 0)          bcnt <= bcnt - 8'd1;
    end
    assign Busy = hang | Start | (bcnt != 8'd0);

    logic signed [7:0] ps;
    logic [7:0]        pu;
    always_comb begin
        ps = $signed({{4{Operand1[3]}}, Operand1}) * $signed({{4{Operand2[3]}}, Operand2});
        pu = {4'b0, Operand1} * {4'b0, Operand2};
        Result1 = '1;
        Result2 = '1;
        case (MCycleOp)
            2'b00: begin Result1 = ps[3:0]; Result2 = ps[7:4]; end
            2'b01: begin Result1 = pu[3:0]; Result2 = pu[7:4]; end
            2'b10: if (Operand2 != 0) begin
                Result1 = $signed(Operand1) / $signed(Operand2);
                Result2 = $signed(Operand1) % $signed(Operand2);
            end
            default: if (Operand2 != 0) begin
                Result1 = Operand1 / Operand2;
                Result2 = Operand1 % Operand2;
            end
        endcase
    end

    // Caller is positioned at a negedge; returns at the negedge after Done.
    task automatic issue(input logic [1:0] op, input logic sel, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res, input int n,
                         input bit scramble, input bit hold);
        int   cyc;
        bit   got;
        exp_t e;
        stub_n = n;
        Req = 1'b1; ReqOp = op; ReqSel = sel; ReqA = a; ReqB = b;
        sb.push_back('{res: exp_res, err: 1'b0});
        #1;
        checks++;
        if (Stall !== 1'b1) $display("FAIL req_cycle_stall: got %b want 1", Stall);
        else passes++;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge CLK);
            cyc++;
            if (Done === 1'b1) begin
                got = 1'b1;
            end else begin
                checks++;
                if (Stall !== 1'b1) $display("FAIL op_stall cyc=%0d: got %b want 1", cyc, Stall);
                else passes++;
                checks++;
                if (Start !== (cyc == 1)) $display("FAIL start_launch_only cyc=%0d: got %b want %b", cyc, Start, (cyc == 1));
                else passes++;
                if (scramble && cyc == 3) begin
                    ReqA = ~a; ReqB = ~b; ReqOp = ~op; ReqSel = ~sel;
                end
                if (scramble && cyc == 4) begin
                    checks++;
                    if (Operand1 !== a || Operand2 !== b || MCycleOp !== op)
                        $display("FAIL latched_operands: got %h/%h/%b want %h/%h/%b",
                                 Operand1, Operand2, MCycleOp, a, b, op);
                    else passes++;
                end
            end
        end
        checks++;
        if (!got) begin
            $display("FAIL done_timeout: no Done within 100 cycles");
            void'(sb.pop_front());
        end else begin
            passes++;
            e = sb.pop_front();
            checks++;
            if (Result !== e.res || Err !== e.err)
                $display("FAIL result: got %h err=%b want %h err=%b", Result, Err, e.res, e.err);
            else passes++;
            checks++;
            if (cyc != n + 2) $display("FAIL latency: got %0d want %0d", cyc, n + 2);
            else passes++;
            checks++;
            if (Stall !== 1'b0) $display("FAIL done_stall: got %b want 0", Stall);
            else passes++;
        end
        if (!hold) Req = 1'b0;
        @(negedge CLK);
        checks++;
        if (Done !== 1'b0 || Stall !== hold)
            $display("FAIL done_pulse: got done=%b stall=%b want 0/%b", Done, Stall, hold);
        else passes++;
    endtask

    task automatic test_reset();
        RESET = 1'b1; Req = 1'b0; ReqOp = 2'b11; ReqSel = 1'b1; ReqA = 4'hA; ReqB = 4'h5;
        repeat (2) @(negedge CLK);
        checks++;
        if (Start !== 1'b0 || Done !== 1'b0 || Err !== 1'b0 || MCycleOp !== 2'b00 ||
            Operand1 !== 4'h0 || Operand2 !== 4'h0 || Result !== 4'h0 || Stall !== 1'b0)
            $display("FAIL reset_state: got st=%b dn=%b er=%b op=%b o1=%h o2=%h r=%h sl=%b want all 0",
                     Start, Done, Err, MCycleOp, Operand1, Operand2, Result, Stall);
        else passes++;
        Req = 1'b1;
        #1;
        checks++;
        if (Stall !== 1'b1) $display("FAIL reset_stall_follows_req: got %b want 1", Stall);
        else passes++;
        Req = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_mul();
        issue(2'b00, 1'b0, 4'b1111, 4'b1111, 4'b0001, 1, 1'b0, 1'b0);
        issue(2'b00, 1'b1, 4'b1111, 4'b1111, 4'b0000, 3, 1'b0, 1'b0);
        issue(2'b01, 1'b0, 4'b1110, 4'b1111, 4'b0010, 2, 1'b0, 1'b0);
        issue(2'b01, 1'b1, 4'b1110, 4'b1111, 4'b1101, 4, 1'b0, 1'b0);
    endtask

    task automatic test_div();
        issue(2'b10, 1'b0, 4'b0111, 4'b1101, 4'b1110, 5, 1'b0, 1'b0);
        issue(2'b10, 1'b1, 4'b0111, 4'b1101, 4'b0001, 1, 1'b0, 1'b0);
        issue(2'b11, 1'b0, 4'd13,   4'd7,    4'b0001, 2, 1'b0, 1'b0);
        issue(2'b11, 1'b1, 4'd13,   4'd7,    4'b0110, 3, 1'b0, 1'b0);
    endtask

    task automatic test_midop_change();
        issue(2'b10, 1'b0, 4'b0111, 4'b1101, 4'b1110, 5, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        issue(2'b01, 1'b0, 4'd3,  4'd5, 4'hF, 2, 1'b0, 1'b1);
        issue(2'b11, 1'b1, 4'd13, 4'd7, 4'h6, 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        stub_n = 10;
        Req = 1'b1; ReqOp = 2'b01; ReqSel = 1'b0; ReqA = 4'd3; ReqB = 4'd3;
        repeat (3) @(negedge CLK);
        RESET = 1'b1; Req = 1'b0;
        #1;
        checks++;
        if (Start !== 1'b0 || Stall !== 1'b0 || Done !== 1'b0 || Operand1 !== 4'h0)
            $display("FAIL abort_state: got st=%b sl=%b dn=%b o1=%h want 0/0/0/0", Start, Stall, Done, Operand1);
        else passes++;
        @(negedge CLK);
        RESET = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (Done === 1'b1 || Stall === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) $display("FAIL abort_no_done: got activity after reset want none");
        else passes++;
        issue(2'b01, 1'b0, 4'd3, 4'd3, 4'b1001, 2, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int   cyc;
        bit   got;
`ifdef MCYCLE_ISSUER_TIMEOUT_EN
        exp_t e;
        stub_n = 1; hang = 1'b1;
        Req = 1'b1; ReqOp = 2'b00; ReqSel = 1'b1; ReqA = 4'd5; ReqB = 4'd6;
        sb.push_back('{res: 4'h0, err: 1'b1});
        cyc = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (Done === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            $display("FAIL timeout_done: no Done within 200 cycles");
            void'(sb.pop_front());
        end else begin
            passes++;
            e = sb.pop_front();
            checks++;
            if (Result !== e.res || Err !== e.err || Start !== 1'b0)
                $display("FAIL timeout_result: got %h err=%b start=%b want %h err=%b start=0",
                         Result, Err, Start, e.res, e.err);
            else passes++;
            checks++;
            if (cyc != TO + 1) $display("FAIL timeout_latency: got %0d want %0d", cyc, TO + 1);
            else passes++;
        end
        Req = 1'b0; hang = 1'b0;
        @(negedge CLK);
        checks++;
        if (Err !== 1'b0 || Done !== 1'b0) $display("FAIL timeout_err_clear: got err=%b done=%b want 0/0", Err, Done);
        else passes++;
`else
        stub_n = 1; hang = 1'b1;
        Req = 1'b1; ReqOp = 2'b00; ReqSel = 1'b0; ReqA = 4'd5; ReqB = 4'd6;
        cyc = 0; got = 1'b0;
        repeat (200) begin
            @(negedge CLK);
            cyc++;
            if (Stall !== 1'b1 || Done === 1'b1 || Err !== 1'b0) got = 1'b1;
        end
        checks++;
        if (got) $display("FAIL hang_stall: got stall drop/done/err want stall held 200 cycles");
        else passes++;
        RESET = 1'b1; Req = 1'b0; hang = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
`endif
        issue(2'b11, 1'b0, 4'd13, 4'd7, 4'b0001, 2, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_midop_change();
        test_back_to_back();
        test_reset_abort();
        test_timeout();
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
